trdos_bus_decoder: RTL and testbench

Z80-side front end for the Beta Disk/TR-DOS floppy controller. It tracks the TR-DOS "DOS active" state from opcode fetches and decodes the WD1793 register ports and system port #FF into registered chip selects for the FDC top level. It also generates the magic-button NMI that forces entry into TR-DOS. It sits between the CPU bus and the FDC; `dos_act` additionally drives the memory mapper's ROM selection.

---
 rtl/trdos_bus_decoder.sv | 147 ++++++++++++++
 tb/tb_trdos_bus_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/trdos_bus_decoder.sv
// rtl/trdos_bus_decoder.sv - TR-DOS bus front end: DOS-active tracking, WD1793/#FF selects, magic-button NMI
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   a[15:0]           CPU address
//   m1_n, mreq_n, iorq_n, rd_n, wr_n   CPU strobes (active-low)
//   rom48             48K BASIC ROM currently mapped at 0000-3FFF
//   fdc_en            controller enable; 0 kills dos_act, selects and NMI
//   nmi_btn           raw magic-button level
//   cs_n              WD1793 register select (#1F/#3F/#5F/#7F), registered
//   csff_n            system port #FF select, registered
//   dos_act           TR-DOS active (also drives ROM selection)
//   nmi_n             NMI to CPU, registered

module trdos_bus_decoder #(
    parameter bit DOS_ON_RESET = 1'b0,
    parameter int NMI_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rom48,
    input  logic        fdc_en,
    input  logic        nmi_btn,
    output logic        cs_n,
    output logic        csff_n,
    output logic        dos_act,
    output logic        nmi_n
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } nmi_state_t;

    localparam logic [7:0] TIMEOUT_INIT = 8'(NMI_TIMEOUT);

    nmi_state_t nmi_state;
    logic [7:0] nmi_cnt;

    logic fetch;
    logic fetch_q;
    logic fetch_start;
    logic io;
    logic btn_s1;
    logic btn_s2;
    logic btn_s3;
    logic btn_rise;
    logic nmi_vec_fetch;
    logic dos_set;
    logic dos_clr;
    logic wd_port;
    logic ff_port;

    assign fetch       = ~m1_n & ~mreq_n & ~rd_n;
    assign fetch_start = fetch & ~fetch_q;

    // m1_n must be high: an interrupt acknowledge also drives iorq_n low.
    assign io = ~iorq_n & m1_n & (~rd_n | ~wr_n);

    assign btn_rise      = btn_s2 & ~btn_s3;
    assign nmi_vec_fetch = fetch_start & (a == 16'h0066);

    // Set and clear address ranges are disjoint, so at most one fires.
    assign dos_set = fetch_start & (((a[15:8] == 8'h3D) & rom48) |
                                    ((a == 16'h0066) & (nmi_state == PEND)));
    assign dos_clr = fetch_start & (a[15:14] != 2'b00);

    assign wd_port = (a[4:0] == 5'h1F) & ~a[7];
    assign ff_port = (a[7:0] == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_q <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_s3  <= 1'b0;
        end else begin
            fetch_q <= fetch;
            btn_s1  <= nmi_btn;
            btn_s2  <= btn_s1;
            btn_s3  <= btn_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dos_act <= DOS_ON_RESET;
        end else if (!fdc_en) begin
            dos_act <= 1'b0;
        end else if (dos_set) begin
            dos_act <= 1'b1;
        end else if (dos_clr) begin
            dos_act <= 1'b0;
        end
    end

    // Selects decode against the dos_act value held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n   <= 1'b1;
            csff_n <= 1'b1;
        end else begin
            cs_n   <= ~(fdc_en & dos_act & io & wd_port);
            csff_n <= ~(fdc_en & dos_act & io & ff_port);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_state <= IDLE;
            nmi_cnt   <= 8'd0;
            nmi_n     <= 1'b1;
        end else begin
            case (nmi_state)
                IDLE: begin
                    nmi_n <= 1'b1;
                    if (btn_rise && fdc_en) begin
                        nmi_state <= PEND;
                        nmi_cnt   <= TIMEOUT_INIT;
                        nmi_n     <= 1'b0;
                    end
                end
                PEND: begin
                    // Low for NMI_TIMEOUT+1 cycles at most: release happens
                    // on the edge after the counter has reached zero.
                    if (!fdc_en || nmi_vec_fetch || (nmi_cnt == 8'd0)) begin
                        nmi_state <= IDLE;
                        nmi_n     <= 1'b1;
                    end else begin
                        nmi_cnt <= nmi_cnt - 8'd1;
                    end
                end
                default: begin
                    nmi_state <= IDLE;
                    nmi_n     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trdos_bus_decoder.sv
// tb/tb_trdos_bus_decoder.sv - self-checking bench for trdos_bus_decoder

module tb_trdos_bus_decoder;

    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
    logic        rom48, fdc_en, nmi_btn;
    logic        cs_n, csff_n, dos_act, nmi_n;

    int n_asserts = 0;
    int n_fail    = 0;

    trdos_bus_decoder #(.DOS_ON_RESET(1'b0), .NMI_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .a(a),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .rom48(rom48), .fdc_en(fdc_en), .nmi_btn(nmi_btn),
        .cs_n(cs_n), .csff_n(csff_n), .dos_act(dos_act), .nmi_n(nmi_n)
    );

    always #5 clk = ~clk;

    // Reference model: state after each edge, button samples indexed by edge number,
    // and the edge number at which a pending NMI times out.
    bit m_dos, m_cs_n, m_csff_n, m_pend, m_prev_fetch;
    int edge_n = 3;
    int deadline = 0;
    bit samp [0:4095];

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        int  n;
        bit  fetch, fs, io, rise, n_dos, n_pend;
        n = edge_n + 1;
        if (reset) begin
            samp[n] = 0; samp[n-1] = 0; samp[n-2] = 0;
            m_dos = 0; m_cs_n = 1; m_csff_n = 1; m_pend = 0; m_prev_fetch = 0;
        end else begin
            samp[n] = nmi_btn;
            fetch = !m1_n && !mreq_n && !rd_n;
            fs    = fetch && !m_prev_fetch;
            io    = !iorq_n && m1_n && (!rd_n || !wr_n);
            rise  = samp[n-2] && !samp[n-3];
            n_dos = m_dos;
            if (!fdc_en) n_dos = 0;
            else if (fs && ((a[15:8] == 8'h3D && rom48) || (a == 16'h0066 && m_pend))) n_dos = 1;
            else if (fs && a >= 16'h4000) n_dos = 0;
            m_cs_n   = !(fdc_en && m_dos && io &&
                         (a[7:0] == 8'h1F || a[7:0] == 8'h3F || a[7:0] == 8'h5F || a[7:0] == 8'h7F));
            m_csff_n = !(fdc_en && m_dos && io && a[7:0] == 8'hFF);
            n_pend = m_pend;
            if (m_pend) begin
                if (!fdc_en || (fs && a == 16'h0066) || n == deadline) n_pend = 0;
            end else if (rise && fdc_en) begin
                n_pend = 1;
                deadline = n + TMO + 1;
            end
            m_dos = n_dos;
            m_pend = n_pend;
            m_prev_fetch = fetch;
        end
        @(posedge clk);
        edge_n = n;
        #1;
        chk("model_dos_act", dos_act, m_dos);
        chk("model_cs_n", cs_n, m_cs_n);
        chk("model_csff_n", csff_n, m_csff_n);
        chk("model_nmi_n", nmi_n, !m_pend);
    endtask

    task automatic bus_idle();
        m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1;
    endtask

    task automatic do_fetch(input logic [15:0] addr, input logic exp_dos);
        a = addr; m1_n = 0; mreq_n = 0; rd_n = 0;
        step();
        chk("fetch_dos_act", dos_act, exp_dos);
        step(); step();
        bus_idle();
        step();
    endtask

    task automatic do_io(input logic [7:0] port, input bit is_wr, input logic exp_cs, input logic exp_ff);
        a = {8'($urandom), port}; iorq_n = 0;
        if (is_wr) wr_n = 0; else rd_n = 0;
        step();
        chk("io_cs_n", cs_n, exp_cs);
        chk("io_csff_n", csff_n, exp_ff);
        step(); step();
        bus_idle();
        step();
        chk("io_release_cs_n", cs_n, 1'b1);
        chk("io_release_csff_n", csff_n, 1'b1);
    endtask

    initial begin
        int low;
        logic [7:0] wd_ports [4];
        wd_ports = '{8'h1F, 8'h3F, 8'h5F, 8'h7F};

        reset = 1; a = 16'h0000; bus_idle(); rom48 = 0; fdc_en = 1; nmi_btn = 0;
        step(); step();
        reset = 0;
        step();
        chk("reset_dos_act", dos_act, 1'b0);
        chk("reset_cs_n", cs_n, 1'b1);
        chk("reset_csff_n", csff_n, 1'b1);
        chk("reset_nmi_n", nmi_n, 1'b1);

        // DOS entry / exit by fetch address
        do_fetch(16'h3D2F, 1'b0);
        rom48 = 1;
        do_fetch(16'h3D2F, 1'b1);
        do_fetch(16'h3FFF, 1'b1);
        a = 16'h8000; mreq_n = 0; rd_n = 0;
        step(); step();
        chk("memrd_no_change", dos_act, 1'b1);
        bus_idle(); step();
        do_fetch(16'h4000, 1'b0);

        // Port selects with DOS active, then inactive
        do_fetch(16'h3D00, 1'b1);
        foreach (wd_ports[i]) do_io(wd_ports[i], 1, 1'b0, 1'b1);
        do_io(8'hFF, 1, 1'b1, 1'b0);
        do_io(8'hFF, 0, 1'b1, 1'b0);
        do_io(8'hFE, 1, 1'b1, 1'b1);
        do_io(8'h9F, 1, 1'b1, 1'b1);
        do_fetch(16'h4000, 1'b0);
        foreach (wd_ports[i]) do_io(wd_ports[i], 1, 1'b1, 1'b1);
        do_io(8'hFF, 1, 1'b1, 1'b1);

        // Interrupt acknowledge never selects #FF
        do_fetch(16'h3D00, 1'b1);
        a = 16'h12FF; m1_n = 0; iorq_n = 0; rd_n = 0;
        step();
        chk("intack_csff_n", csff_n, 1'b1);
        step(); bus_idle(); step();

        // Magic button, taken by #0066 fetch
        do_fetch(16'h4000, 1'b0);
        nmi_btn = 1;
        step(); chk("nmi_lat1", nmi_n, 1'b1);
        step(); chk("nmi_lat2", nmi_n, 1'b1);
        step(); chk("nmi_lat3", nmi_n, 1'b0);
        nmi_btn = 0;
        a = 16'h0066; m1_n = 0; mreq_n = 0; rd_n = 0;
        step();
        chk("nmi_taken_nmi_n", nmi_n, 1'b1);
        chk("nmi_taken_dos", dos_act, 1'b1);
        step(); bus_idle(); step();

        // Magic button, timeout
        nmi_btn = 1; step(); nmi_btn = 0; step(); step();
        low = (nmi_n === 1'b0) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (nmi_n === 1'b0) low++;
        end
        chk_int("nmi_timeout_low_cycles", low, TMO + 1);
        chk("nmi_timeout_dos", dos_act, 1'b1);

        // Controller disabled
        fdc_en = 0; step();
        chk("fdc_off_dos", dos_act, 1'b0);
        do_fetch(16'h3D00, 1'b0);
        nmi_btn = 1; step(); nmi_btn = 0;
        for (int i = 0; i < 5; i++) step();
        chk("fdc_off_nmi", nmi_n, 1'b1);
        fdc_en = 1; step();
        nmi_btn = 1; step(); nmi_btn = 0; step(); step();
        chk("pend_before_drop", nmi_n, 1'b0);
        fdc_en = 0; step();
        chk("fdc_drop_nmi", nmi_n, 1'b1);
        fdc_en = 1; step();

        // Reset in the middle of an OUT to #1F
        do_fetch(16'h3D00, 1'b1);
        a = 16'h001F; iorq_n = 0; wr_n = 0;
        step();
        chk("out1f_cs_n", cs_n, 1'b0);
        reset = 1; step();
        chk("reset_mid_cs_n", cs_n, 1'b1);
        chk("reset_mid_dos", dos_act, 1'b0);
        bus_idle(); reset = 0; step();

        // Random bus traffic against the model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: a = {8'h3D, 8'($urandom)};
                1: a = 16'h0066;
                2: a = 16'h4000 | 16'($urandom_range(0, 16'hBFFF));
                3: a = {8'($urandom), 3'($urandom), 5'h1F};
                4: a = {8'($urandom), 8'hFF};
                default: a = 16'($urandom);
            endcase
            m1_n    = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            mreq_n  = 1'($urandom);
            iorq_n  = 1'($urandom);
            rd_n    = 1'($urandom);
            wr_n    = 1'($urandom);
            rom48   = 1'($urandom);
            fdc_en  = ($urandom_range(0, 19) != 0);
            nmi_btn = ($urandom_range(0, 14) == 0);
            reset   = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
